// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// and the alignment check used when a request is accepted.
package lsu_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFS_W = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } lsu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RMW_READ = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_e;

  // The illegal size encoding is reported the same way as a misaligned access.
  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts and extends load data from a memory word, and
// merges sub-word store data into the word read back for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  lsu_size_e   i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_rdata,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    w_sign      = 1'b0;
    o_load_data = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        w_sign      = ~i_unsigned & w_byte[7];
        o_load_data = {{24{w_sign}}, w_byte};
      end
      SZ_HALF: begin
        w_sign      = ~i_unsigned & w_half[15];
        o_load_data = {{16{w_sign}}, w_half};
      end
      default: o_load_data = i_rdata;
    endcase
  end

  // Lanes not addressed by the store keep the value just read from memory.
  always_comb begin
    o_merge_data = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        case (i_addr_lo)
          2'd0:    o_merge_data[7:0]   = i_wdata[7:0];
          2'd1:    o_merge_data[15:8]  = i_wdata[7:0];
          2'd2:    o_merge_data[23:16] = i_wdata[7:0];
          default: o_merge_data[31:24] = i_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (i_addr_lo[1]) o_merge_data[31:16] = i_wdata;
        else              o_merge_data[15:0]  = i_wdata;
      end
      default: o_merge_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, checks it, then drives a
// combinational-read word memory (direct read, or read-modify-write for sub-word stores).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_error,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_we,
  input  logic [31:0] i_mem_rdata,
  output logic [2:0]  o_dbg_state
);

  // Handshakes: a request transfers on a rising edge where i_req_valid && o_req_ready;
  // a response transfers on a rising edge where o_rsp_valid && i_rsp_ready. While
  // valid is high the producer holds its payload stable.

  lsu_state_e  r_state;
  logic [1:0]  r_addr_lo;
  lsu_size_e   r_size;
  logic        r_unsigned;
  logic [15:0] r_wdata;

  lsu_size_e   w_req_size;
  logic [31:0] w_word_idx;
  logic        w_out_of_range;
  logic        w_req_err;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  assign w_req_size     = lsu_size_e'(i_req_size);
  assign w_word_idx     = i_req_addr >> BYTE_OFS_W;
  assign w_out_of_range = (w_word_idx >= 32'(MEM_WORDS));
  assign w_req_err      = is_misaligned(w_req_size, i_req_addr[1:0]) | w_out_of_range;

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_dbg_state = r_state;

  lsu_align u_align (
    .i_addr_lo    (r_addr_lo),
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_rdata      (i_mem_rdata),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_addr_lo   <= 2'b00;
      r_size      <= SZ_BYTE;
      r_unsigned  <= 1'b0;
      r_wdata     <= 16'h0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= 32'h0;
      o_rsp_error <= 1'b0;
      o_mem_addr  <= 32'h0;
      o_mem_wdata <= 32'h0;
      o_mem_we    <= 1'b0;
    end else begin
      o_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_addr_lo   <= i_req_addr[1:0];
            r_size      <= w_req_size;
            r_unsigned  <= i_req_unsigned;
            r_wdata     <= i_req_wdata[15:0];
            o_rsp_rdata <= 32'h0;
            if (w_req_err) begin
              // Rejected requests never touch memory; the address register is left as is.
              o_rsp_error <= 1'b1;
              o_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              o_rsp_error <= 1'b0;
              o_mem_addr  <= w_word_idx;
              if (!i_req_we) begin
                r_state <= ST_LOAD;
              end else if (w_req_size == SZ_WORD) begin
                o_mem_wdata <= i_req_wdata;
                o_mem_we    <= 1'b1;
                r_state     <= ST_WRITE;
              end else begin
                r_state <= ST_RMW_READ;
              end
            end
          end
        end
        ST_LOAD: begin
          o_rsp_rdata <= w_load_data;
          o_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RMW_READ: begin
          o_mem_wdata <= w_merge_data;
          o_mem_we    <= 1'b1;
          r_state     <= ST_WRITE;
        end
        ST_WRITE: begin
          o_rsp_rdata <= 32'h0;
          o_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          o_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word memory, directed vector table,
// response stall and mid-operation reset sequences, then random traffic.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid, i_req_we, i_req_unsigned, i_rsp_ready;
  logic [1:0]  i_req_size;
  logic [31:0] i_req_addr, i_req_wdata;
  logic        o_req_ready, o_rsp_valid, o_rsp_error, o_mem_we;
  logic [31:0] o_rsp_rdata, o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic [2:0]  o_dbg_state;

  logic [31:0] mem    [0:63];
  logic [31:0] sh_mem [0:63];
  logic [32:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_wword;
    int          exp_lat;
  } vec_t;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_error(o_rsp_error),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
    .i_mem_rdata(i_mem_rdata), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  assign i_mem_rdata = (o_mem_addr < 32'd64) ? mem[o_mem_addr[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (o_mem_we && o_mem_addr < 32'd64) mem[o_mem_addr[5:0]] <= o_mem_wdata;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Byte-array reference of the unit; updates the shadow memory on stores.
  task automatic ref_model(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic err, output logic [31:0] rdata,
                           output logic [31:0] wword, output int lat);
    logic [7:0] b [0:3];
    int a, w;
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
          (size == 2'd2 && addr[1:0] != 2'b00) || (addr >= 32'd256);
    rdata = 32'h0;
    wword = 32'h0;
    if (err) begin
      lat = 1;
      return;
    end
    a = int'(addr[1:0]);
    w = int'(addr[7:2]);
    for (int k = 0; k < 4; k++) b[k] = sh_mem[w][8*k +: 8];
    if (!we) begin
      lat = 2;
      if (size == 2'd0)      rdata = uns ? {24'h0, b[a]} : {{24{b[a][7]}}, b[a]};
      else if (size == 2'd1) rdata = uns ? {16'h0, b[a+1], b[a]} : {{16{b[a+1][7]}}, b[a+1], b[a]};
      else                   rdata = {b[3], b[2], b[1], b[0]};
    end else begin
      lat = (size == 2'd2) ? 2 : 3;
      if (size == 2'd0) b[a] = wdata[7:0];
      else if (size == 2'd1) begin
        b[a] = wdata[7:0];
        b[a+1] = wdata[15:8];
      end else for (int k = 0; k < 4; k++) b[k] = wdata[8*k +: 8];
      wword = {b[3], b[2], b[1], b[0]};
      sh_mem[w] = wword;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_req(input vec_t v, input int stall, input string tag);
    int lat, we_cnt, we_at;
    logic exp_we;
    logic [32:0] exp;
    logic [31:0] held_rdata;
    logic held_err;
    @(negedge clk);
    check({tag, " req_ready"}, 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1;
    i_req_we = v.we;
    i_req_size = v.size;
    i_req_unsigned = v.uns;
    i_req_addr = v.addr;
    i_req_wdata = v.wdata;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    lat = 0;
    we_cnt = 0;
    we_at = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) i_req_valid = 1'b0;
      if (o_mem_we) begin
        we_cnt++;
        we_at = c;
        check({tag, " mem_addr"}, o_mem_addr, v.addr >> 2);
        check({tag, " mem_wdata"}, o_mem_wdata, v.exp_wword);
      end
      if (o_rsp_valid) begin
        lat = c;
        break;
      end
    end
    check({tag, " latency"}, lat, v.exp_lat);
    exp_we = v.we && !v.exp_err;
    check({tag, " we_pulses"}, we_cnt, {31'h0, exp_we});
    if (exp_we) check({tag, " we_cycle"}, we_at, v.exp_lat - 1);
    exp = exp_q.pop_front();
    if (lat != 0) begin
      check({tag, " rsp_error"}, 32'(o_rsp_error), 32'(exp[32]));
      check({tag, " rsp_rdata"}, o_rsp_rdata, exp[31:0]);
      held_rdata = o_rsp_rdata;
      held_err = o_rsp_error;
      for (int k = 0; k < stall; k++) begin
        i_req_valid = 1'b1;
        i_req_we = 1'b1;
        i_req_size = 2'd2;
        i_req_addr = 32'h0;
        i_req_wdata = 32'h5A5A5A5A;
        @(negedge clk);
        check({tag, " stall_valid"}, 32'(o_rsp_valid), 32'd1);
        check({tag, " stall_rdata"}, o_rsp_rdata, held_rdata);
        check({tag, " stall_error"}, 32'(o_rsp_error), 32'(held_err));
        check({tag, " stall_ready"}, 32'(o_req_ready), 32'd0);
        check({tag, " stall_we"}, 32'(o_mem_we), 32'd0);
      end
      i_req_valid = 1'b0;
      i_rsp_ready = 1'b1;
      @(negedge clk);
      i_rsp_ready = 1'b0;
      check({tag, " rsp_drop"}, 32'(o_rsp_valid), 32'd0);
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[$];
  vec_t v;
  logic dmy_err;
  logic [31:0] dmy_rd, dmy_ww, saved;
  int dmy_lat, pulses;
  int rsel;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h0;
      sh_mem[i] = 32'h0;
    end
    mem[3] = 32'hDEADBEEF;   sh_mem[3] = 32'hDEADBEEF;
    mem[63] = 32'h80000001;  sh_mem[63] = 32'h80000001;
    i_rst = 1'b1;
    i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'd0; i_req_unsigned = 1'b0;
    i_req_addr = 32'h0; i_req_wdata = 32'h0; i_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    check("reset state", 32'(o_dbg_state), 32'(ST_IDLE));
    check("reset rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("reset rsp_rdata", o_rsp_rdata, 32'h0);
    check("reset mem_we", 32'(o_mem_we), 32'd0);
    check("reset mem_addr", o_mem_addr, 32'h0);
    check("reset mem_wdata", o_mem_wdata, 32'h0);

    //           we    size  uns   addr          wdata         exp_rdata     err   exp_wword     lat
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h0000000D, 32'h0,        32'hFFFFFFBE, 1'b0, 32'h0,        2});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h0000000D, 32'h0,        32'h000000BE, 1'b0, 32'h0,        2});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h0000000E, 32'h0,        32'h0000DEAD, 1'b0, 32'h0,        2});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h0000000C, 32'h0,        32'hFFFFBEEF, 1'b0, 32'h0,        2});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h0000000C, 32'h00001234, 32'h0,        1'b0, 32'hDEAD1234, 3});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h0000000C, 32'h0,        32'hDEAD1234, 1'b0, 32'h0,        2});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h00000010, 32'hCAFEF00D, 32'h0,        1'b0, 32'hCAFEF00D, 2});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h00000010, 32'h0,        32'hCAFEF00D, 1'b0, 32'h0,        2});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h00000011, 32'h000000AB, 32'h0,        1'b0, 32'hCAFEAB0D, 3});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h00000011, 32'h0,        32'hFFFFFFAB, 1'b0, 32'h0,        2});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h00000013, 32'h0,        32'h000000CA, 1'b0, 32'h0,        2});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h000000FC, 32'h0,        32'h80000001, 1'b0, 32'h0,        2});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h0000000E, 32'h0,        32'h0,        1'b1, 32'h0,        1});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h0000000F, 32'h0000FFFF, 32'h0,        1'b1, 32'h0,        1});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h00000010, 32'h0,        32'h0,        1'b1, 32'h0,        1});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h00000100, 32'h0,        32'h0,        1'b1, 32'h0,        1});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h00000100, 32'h11111111, 32'h0,        1'b1, 32'h0,        1});

    foreach (tbl[i]) begin
      ref_model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                dmy_err, dmy_rd, dmy_ww, dmy_lat);
      run_req(tbl[i], 0, $sformatf("vec%0d", i));
    end

    // Response held off for three cycles while a competing store is presented.
    v = '{1'b0, 2'd2, 1'b0, 32'h00000010, 32'h0, 32'hCAFEAB0D, 1'b0, 32'h0, 2};
    run_req(v, 3, "stall");
    check("stall ignored store", mem[0], 32'h0);

    // Reset while the byte store is in its read phase.
    saved = mem[3];
    @(negedge clk);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'd0; i_req_unsigned = 1'b0;
    i_req_addr = 32'h0000000C; i_req_wdata = 32'h00000055;
    @(negedge clk);
    i_req_valid = 1'b0;
    check("rst_mid state before", 32'(o_dbg_state), 32'(ST_RMW_READ));
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check("rst_mid state", 32'(o_dbg_state), 32'(ST_IDLE));
    check("rst_mid rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_mid rsp_rdata", o_rsp_rdata, 32'h0);
    check("rst_mid rsp_error", 32'(o_rsp_error), 32'd0);
    check("rst_mid mem_addr", o_mem_addr, 32'h0);
    check("rst_mid mem_wdata", o_mem_wdata, 32'h0);
    check("rst_mid req_ready", 32'(o_req_ready), 32'd1);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (o_mem_we) pulses++;
      @(negedge clk);
    end
    check("rst_mid we_pulses", pulses, 0);
    check("rst_mid mem word", mem[3], saved);

    // Random traffic over the low words with occasional bad requests.
    for (int i = 0; i < 30; i++) begin
      v.we = 1'($urandom_range(0, 1));
      rsel = int'($urandom_range(0, 9));
      v.size = (rsel < 3) ? 2'd0 : (rsel < 6) ? 2'd1 : (rsel < 9) ? 2'd2 : 2'd3;
      v.uns = 1'($urandom_range(0, 1));
      v.addr = ($urandom_range(0, 9) == 0) ? 32'h100 + $urandom_range(0, 255) : $urandom_range(0, 31);
      v.wdata = $urandom;
      ref_model(v.we, v.size, v.uns, v.addr, v.wdata, v.exp_err, v.exp_rdata, v.exp_wword, v.exp_lat);
      run_req(v, int'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 8; i++) check($sformatf("final mem%0d", i), mem[i], sh_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data memory interface: accepts one load/store request at a time from the core pipeline and drives the word-wide, combinational-read data memory.
- Handles byte, halfword and word accesses, with sign or zero extension on loads and read-modify-write for sub-word stores.
- Flags misaligned or out-of-range accesses.
- Sits between the execute stage and the data memory.

Parameters:
MEM_WORDS, 64, depth of attached data memory in 32-bit words; word index >= MEM_WORDS is out of range

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset
i_req_valid  input  1  request present
o_req_ready  output  1  unit can accept request (high only in IDLE)
i_req_we  input  1  1=store, 0=load
i_req_size  input  2  0=byte, 1=halfword, 2=word, 3=illegal (treated as misaligned)
i_req_unsigned  input  1  load zero-extends when 1 (LBU/LHU)
i_req_addr  input  32  byte address
i_req_wdata  input  32  store data, right-aligned
o_rsp_valid  output  1  response present
i_rsp_ready  input  1  consumer takes response
o_rsp_rdata  output  32  load result, extended; 0 for stores and errors
o_rsp_error  output  1  misaligned, illegal size or out of range
o_mem_addr  output  32  word index = byte address >> 2
o_mem_wdata  output  32  full word to write
o_mem_we  output  1  write enable, one cycle per store
i_mem_rdata  input  32  memory read data, combinational from o_mem_addr

Behaviour:
- Reset: one clock; reset is synchronous and active-high (i_clk, i_rst).
  - State goes to IDLE.
  - o_rsp_valid=0, o_rsp_rdata=0, o_rsp_error=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0.
  - Reset in any state aborts the operation. No o_mem_we is issued in the reset cycle or after it.
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid, latch addr, size, unsigned, we and wdata.
  - Error check: size=3; size=1 with addr[0]!=0; size=2 with addr[1:0]!=0; (addr>>2) >= MEM_WORDS. Any error goes to RESP with error=1 and makes no memory access.
  - Otherwise: load goes to LOAD; word store goes to WRITE; byte or half store goes to RMW_READ.
- LOAD:
  - Drive o_mem_addr.
  - Select the lane by addr[1:0] and extend: sign from the top bit of the lane unless unsigned.
  - Register the result into o_rsp_rdata, then go to RESP.
- RMW_READ:
  - Drive o_mem_addr and capture i_mem_rdata.
  - Replace the byte lane addr[1:0] (byte) or halfword lane addr[1] (half) with the low bits of wdata; other lanes unchanged.
  - Go to WRITE.
- WRITE:
  - o_mem_we=1 for exactly this cycle, with o_mem_addr and o_mem_wdata stable.
  - Go to RESP with rdata=0.
- RESP:
  - o_rsp_valid=1. rdata and error are held stable until i_rsp_ready.
  - On i_rsp_ready go to IDLE. The next request is accepted at the earliest in the following cycle (no same-cycle bypass).
- Latency from accept edge to o_rsp_valid:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- o_mem_we is 0 in every state except WRITE. o_mem_addr is don't-care but held in IDLE/RESP.
- i_req_* are ignored outside IDLE.

Decomposition:
- Package lsu_pkg:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state enum
  - constant WORD_BYTES=4
- One combinational sub-module, lsu_align: lane extract plus extension for loads, and lane merge for stores, driven by addr[1:0], size and unsigned. The FSM stays in the top.

Test Plan:
- Memory word 3 = 0xDEADBEEF:
  - LB addr 0x0D -> o_rsp_rdata=0xFFFFFFBE, error=0, rsp_valid 2 cycles after accept.
  - LBU addr 0x0D -> 0x000000BE.
  - LHU addr 0x0E -> 0x0000DEAD.
- SH wdata 0x00001234 addr 0x0C on word 0xDEADBEEF -> single o_mem_we pulse 2 cycles after accept, o_mem_wdata=0xDEAD1234, rsp_valid at cycle 3.
- SW 0xCAFEF00D addr 0x10 -> o_mem_we 1 cycle after accept, o_mem_addr=4, o_mem_wdata=0xCAFEF00D; then LW 0x10 -> 0xCAFEF00D.
- Each of these -> error=1, rdata=0, no o_mem_we, rsp_valid 1 cycle after accept:
  - LW 0x0E
  - SH 0x0F
  - size=3
  - LW 0x100 (word 64, MEM_WORDS=64)
- Hold i_rsp_ready=0 for 3 cycles -> o_rsp_valid/rdata/error stable, o_req_ready=0, new i_req_valid ignored.
- Assert i_rst during RMW_READ of SB -> no o_mem_we ever, memory word unchanged, next cycle state IDLE with all outputs at reset values.
